// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM->WB stage buffer: default field widths,
// payload layout and a payload-width helper.
// Payload concat order (MSB..LSB): {load, rf_en, rd, alu_data, load_data, wb_data}.
package mem_wb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned RD_W_DEF   = 4;
  localparam int unsigned CNT_W_DEF  = 16;

  // Payload at default widths; the parametrised RTL uses the same layout
  // as a flat vector sized by payload_w().
  typedef struct packed {
    logic                  load;
    logic                  rf_en;
    logic [RD_W_DEF-1:0]   rd;
    logic [DATA_W_DEF-1:0] alu_data;
    logic [DATA_W_DEF-1:0] load_data;
    logic [DATA_W_DEF-1:0] wb_data;
  } mem_wb_payload_t;

  // Total payload width for a given data and Rd width.
  function automatic int unsigned payload_w(input int unsigned dw, input int unsigned rw);
    return 2 + rw + 3 * dw;
  endfunction

endpackage

// File: rtl/mem_wb_skid_slot.sv
// Generic payload register with a valid flop.
// i_clear has priority and only drops valid (payload may go stale).
// i_load writes i_valid into the valid flop; the payload is only captured
// when the incoming entry is valid, so an emptied slot keeps its old data.
module mem_wb_skid_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Valid flop: clear beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
    end
  end

  // Payload register: captures only real beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (!i_clear && i_load && i_valid) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/mem_wb_stage_buf.sv
// MEM->WB pipeline stage buffer with valid/ready, synchronous flush,
// registered write-back select and a saturating stall counter.
// Build option: define MEM_WB_SKID_EN for a 2-entry (output + skid) buffer
// with a registered in_ready; otherwise a single register with a
// combinational in_ready.
module mem_wb_stage_buf
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_W   = RD_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_load_data,
  input  logic [DATA_W-1:0] in_alu_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_load,
  input  logic              in_rf_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_wb_data,
  output logic [DATA_W-1:0] out_load_data,
  output logic [DATA_W-1:0] out_alu_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_load,
  output logic              out_rf_we,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned PW = payload_w(DATA_W, RD_W);

  // Field offsets inside the flat payload vector.
  localparam int unsigned WB_LSB  = 0;
  localparam int unsigned LD_LSB  = DATA_W;
  localparam int unsigned ALU_LSB = 2 * DATA_W;
  localparam int unsigned RD_LSB  = 3 * DATA_W;
  localparam int unsigned RF_BIT  = 3 * DATA_W + RD_W;
  localparam int unsigned LDF_BIT = 3 * DATA_W + RD_W + 1;

  logic [DATA_W-1:0] w_in_wb;
  logic [PW-1:0]     w_in_payload;
  logic [PW-1:0]     w_out_payload;
  logic              w_out_valid;
  logic              w_out_en;
  logic [CNT_W-1:0]  r_stall_cnt;

  // Write-back select is resolved on the way in so the output is a plain flop.
  assign w_in_wb      = in_load ? in_load_data : in_alu_data;
  assign w_in_payload = {in_load, in_rf_en, in_rd, in_alu_data, in_load_data, w_in_wb};

  // Output register may load when empty or when its beat is leaving.
  assign w_out_en = !w_out_valid || out_ready;

`ifdef MEM_WB_SKID_EN

  logic          w_skid_valid;
  logic [PW-1:0] w_skid_payload;
  logic          w_in_acc;
  logic          w_out_src_valid;
  logic [PW-1:0] w_out_src;
  logic          w_skid_load;
  logic          w_skid_vin;

  // in_ready is the inverted skid valid flop, so out_ready never reaches it
  // combinationally; with an empty skid a stalled output parks the beat there.
  assign w_in_acc        = in_valid && !w_skid_valid;
  assign w_out_src_valid = w_skid_valid || w_in_acc;
  assign w_out_src       = w_skid_valid ? w_skid_payload : w_in_payload;
  // Skid is rewritten whenever the output drains (emptying it) or when a beat
  // is accepted while the output stalls (filling it).
  assign w_skid_load     = w_out_en || w_in_acc;
  assign w_skid_vin      = !w_out_en && w_in_acc;

  mem_wb_skid_slot #(.W(PW)) u_out_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (flush),
    .i_load  (w_out_en),
    .i_valid (w_out_src_valid),
    .i_data  (w_out_src),
    .o_valid (w_out_valid),
    .o_data  (w_out_payload)
  );

  mem_wb_skid_slot #(.W(PW)) u_skid_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (flush),
    .i_load  (w_skid_load),
    .i_valid (w_skid_vin),
    .i_data  (w_in_payload),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_payload)
  );

  assign in_ready = !w_skid_valid;

`else

  mem_wb_skid_slot #(.W(PW)) u_out_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (flush),
    .i_load  (w_out_en),
    .i_valid (in_valid),
    .i_data  (w_in_payload),
    .o_valid (w_out_valid),
    .o_data  (w_out_payload)
  );

  assign in_ready = w_out_en;

`endif

  // Stall counter: counts held-but-not-consumed cycles, saturates, survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid     = w_out_valid;
  assign out_wb_data   = w_out_payload[WB_LSB  +: DATA_W];
  assign out_load_data = w_out_payload[LD_LSB  +: DATA_W];
  assign out_alu_data  = w_out_payload[ALU_LSB +: DATA_W];
  assign out_rd        = w_out_payload[RD_LSB  +: RD_W];
  assign out_load      = w_out_payload[LDF_BIT];
  assign out_rf_we     = w_out_valid && w_out_payload[RF_BIT];
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// Self-checking bench for mem_wb_stage_buf (works with or without MEM_WB_SKID_EN).
module tb_mem_wb_stage_buf;

`ifdef MEM_WB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_load_data;
  logic [31:0] in_alu_data;
  logic [3:0]  in_rd;
  logic        in_load;
  logic        in_rf_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_wb_data;
  logic [31:0] out_load_data;
  logic [31:0] out_alu_data;
  logic [3:0]  out_rd;
  logic        out_load;
  logic        out_rf_we;
  logic [15:0] stall_cnt;

  logic        in_ready2, out_valid2, out_load2, out_rf_we2;
  logic [31:0] out_wb_data2, out_load_data2, out_alu_data2;
  logic [3:0]  out_rd2;
  logic [1:0]  stall_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage_buf #(.DATA_W(32), .RD_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_load_data(in_load_data), .in_alu_data(in_alu_data),
    .in_rd(in_rd), .in_load(in_load), .in_rf_en(in_rf_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wb_data(out_wb_data), .out_load_data(out_load_data),
    .out_alu_data(out_alu_data), .out_rd(out_rd), .out_load(out_load),
    .out_rf_we(out_rf_we), .stall_cnt(stall_cnt)
  );

  mem_wb_stage_buf #(.DATA_W(32), .RD_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_load_data(in_load_data), .in_alu_data(in_alu_data),
    .in_rd(in_rd), .in_load(in_load), .in_rf_en(in_rf_en),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_wb_data(out_wb_data2), .out_load_data(out_load_data2),
    .out_alu_data(out_alu_data2), .out_rd(out_rd2), .out_load(out_load2),
    .out_rf_we(out_rf_we2), .stall_cnt(stall_cnt2)
  );

  typedef struct {
    logic        v;
    logic        ld;
    logic        rf;
    logic        fl;
    logic [31:0] ldd;
    logic [31:0] alu;
    logic [3:0]  rd;
    logic        e_v;
    logic        e_we;
    logic [31:0] e_wb;
  } vec_t;

  vec_t tbl[7];

  function automatic vec_t mk(input logic v, input logic ld, input logic rf, input logic fl,
                              input logic [31:0] ldd, input logic [31:0] alu, input logic [3:0] rd,
                              input logic e_v, input logic e_we, input logic [31:0] e_wb);
    vec_t t;
    t.v = v; t.ld = ld; t.rf = rf; t.fl = fl; t.ldd = ldd; t.alu = alu; t.rd = rd;
    t.e_v = e_v; t.e_we = e_we; t.e_wb = e_wb;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic v, input logic ld, input logic [31:0] ldd,
                          input logic [31:0] alu, input logic [3:0] rd, input logic rf);
    in_valid = v; in_load = ld; in_load_data = ldd; in_alu_data = alu; in_rd = rd; in_rf_en = rf;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_beat(1'b0, 1'b0, '0, '0, '0, 1'b0);
    step(); step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Row: v ld rf fl load_data alu rd | exp valid, exp rf_we, exp wb_data
    tbl[0] = mk(1, 1, 1, 0, 32'hDEADBEEF, 32'h00001234, 4'd5,  1, 1, 32'hDEADBEEF);
    tbl[1] = mk(0, 0, 0, 0, 32'h0,        32'h0,        4'd0,  0, 0, 32'h0);
    tbl[2] = mk(1, 0, 1, 0, 32'h00001111, 32'hCAFE0001, 4'd3,  1, 1, 32'hCAFE0001);
    tbl[3] = mk(1, 0, 0, 0, 32'h00000099, 32'h00000077, 4'd9,  1, 0, 32'h00000077);
    tbl[4] = mk(1, 1, 1, 1, 32'h0000ABCD, 32'h00000001, 4'd15, 0, 0, 32'h0);
    tbl[5] = mk(1, 1, 1, 0, 32'h00000055, 32'h00000066, 4'd2,  1, 1, 32'h00000055);
    tbl[6] = mk(0, 0, 0, 0, 32'h0,        32'h0,        4'd0,  0, 0, 32'h0);

    do_reset();
    chk("reset_valid", out_valid, 0);
    chk("reset_stall", stall_cnt, 0);
    chk("reset_in_ready", in_ready, 1);

    // Table vectors with out_ready held high.
    for (int i = 0; i < 7; i++) begin
      set_beat(tbl[i].v, tbl[i].ld, tbl[i].ldd, tbl[i].alu, tbl[i].rd, tbl[i].rf);
      flush = tbl[i].fl;
      step();
      flush = 1'b0;
      chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].e_v);
      chk($sformatf("vec%0d_we", i), out_rf_we, tbl[i].e_we);
      if (tbl[i].e_v) begin
        chk($sformatf("vec%0d_wb", i), out_wb_data, tbl[i].e_wb);
        chk($sformatf("vec%0d_rd", i), out_rd, tbl[i].rd);
        chk($sformatf("vec%0d_load", i), out_load, tbl[i].ld);
        chk($sformatf("vec%0d_ldd", i), out_load_data, tbl[i].ldd);
        chk($sformatf("vec%0d_alu", i), out_alu_data, tbl[i].alu);
      end
    end

    // Back-to-back 8 beats, no bubbles.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_beat(1'b1, i[0], 32'h100 + i, 32'h200 + i, i[3:0], 1'b1);
      step();
      chk($sformatf("b2b%0d_valid", i), out_valid, 1);
      chk($sformatf("b2b%0d_rd", i), out_rd, i[3:0]);
      chk($sformatf("b2b%0d_wb", i), out_wb_data, i[0] ? 32'h100 + i : 32'h200 + i);
    end
    set_beat(1'b0, 1'b0, '0, '0, '0, 1'b0);
    step();
    chk("b2b_drain", out_valid, 0);

    // Stall with beat held and another beat waiting.
    do_reset();
    set_beat(1'b1, 1'b0, 32'hAAAA0000, 32'h0A0A0A0A, 4'd7, 1'b1);
    step();
    out_ready = 1'b0;
    set_beat(1'b1, 1'b1, 32'hBBBB0000, 32'h0B0B0B0B, 4'd8, 1'b1);
    #1;
    chk("stall_in_ready_first", in_ready, SKID);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("stall%0d_alu", k), out_alu_data, 32'h0A0A0A0A);
      chk($sformatf("stall%0d_rd", k), out_rd, 4'd7);
      chk($sformatf("stall%0d_we", k), out_rf_we, 1);
      chk($sformatf("stall%0d_cnt", k), stall_cnt, k);
      chk($sformatf("stall%0d_in_ready", k), in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk("stall_rel_valid", out_valid, 1);
    chk("stall_rel_wb", out_wb_data, 32'hBBBB0000);
    chk("stall_rel_rd", out_rd, 4'd8);
    set_beat(1'b0, 1'b0, '0, '0, '0, 1'b0);
    step();
    chk("stall_end_valid", out_valid, 0);
    chk("stall_end_cnt", stall_cnt, 3);

    // Flush with output (and skid, if present) full and a beat arriving.
    do_reset();
    set_beat(1'b1, 1'b1, 32'h11111111, 32'h22222222, 4'd1, 1'b1);
    step();
    out_ready = 1'b0;
    set_beat(1'b1, 1'b1, 32'h33333333, 32'h44444444, 4'd2, 1'b1);
    step();
    set_beat(1'b1, 1'b1, 32'h55555555, 32'h66666666, 4'd3, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_we", out_rf_we, 0);
    chk("flush_stall_kept", stall_cnt, 2);
    set_beat(1'b0, 1'b0, '0, '0, '0, 1'b0);
    #1;
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("flush_nothing_emerges", out_valid, 0);
    chk("flush_nothing_we", out_rf_we, 0);

    // Saturating counter on the narrow instance.
    do_reset();
    set_beat(1'b1, 1'b0, 32'h0, 32'h9, 4'd4, 1'b1);
    step();
    out_ready = 1'b0;
    set_beat(1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("sat%0d_cnt2", k), stall_cnt2, (k > 3) ? 3 : k);
      chk($sformatf("sat%0d_cnt16", k), stall_cnt, k);
    end
    out_ready = 1'b1;
    step();

    // Asynchronous reset mid-stream, asserted between clock edges.
    set_beat(1'b1, 1'b1, 32'hFEEDF00D, 32'h12345678, 4'd6, 1'b1);
    step();
    out_ready = 1'b0;
    set_beat(1'b0, 1'b0, '0, '0, '0, 1'b0);
    step();
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_we", out_rf_we, 0);
    chk("arst_wb", out_wb_data, 0);
    chk("arst_ldd", out_load_data, 0);
    chk("arst_alu", out_alu_data, 0);
    chk("arst_rd", out_rd, 0);
    chk("arst_load", out_load, 0);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
